// File: rtl/web_fire_arbiter.sv
// web_fire_arbiter
//   Shares one web-shooter resource pool (fluid, energy, tracer) between the
//   left and right wrist fire requesters. Requests are arbitrated round-robin,
//   checked for sufficiency against the pool, and a granted shot debits all
//   three resources in one edge. Refill (fluid only) and a post-shot cooldown
//   are sequenced here. Running energy down to zero latches a terminal DEAD
//   state that only rst_n clears.
//
// Ports
//   clk, rst_n            clock (posedge), asynchronous active-low reset
//   req[1:0]              level fire request per requester
//   need_f0/e0/t0         resource cost of a requester-0 shot
//   need_f1/e1/t1         resource cost of a requester-1 shot
//   refill_req            level refill request (fluid reloads to REFILL_F)
//   grant[1:0]            one-hot pulse: shot issued, pool debited
//   deny[1:0]             one-hot pulse: shot refused, pool unchanged
//   busy                  high outside IDLE and DEAD
//   fluid/energy/tracer   current pool levels (registered)
//   dead                  sticky, energy reached zero
module web_fire_arbiter #(
    parameter int FLUID_W  = 5,
    parameter int ENERGY_W = 9,
    parameter int TRACER_W = 7,
    parameter int REFILL_F = 16,
    parameter int INIT_E   = 256,
    parameter int INIT_T   = 64,
    parameter int COOLDOWN = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    input  logic [FLUID_W-1:0]  need_f0,
    input  logic [FLUID_W-1:0]  need_f1,
    input  logic [ENERGY_W-1:0] need_e0,
    input  logic [ENERGY_W-1:0] need_e1,
    input  logic [TRACER_W-1:0] need_t0,
    input  logic [TRACER_W-1:0] need_t1,
    input  logic                refill_req,
    output logic [1:0]          grant,
    output logic [1:0]          deny,
    output logic                busy,
    output logic [FLUID_W-1:0]  fluid,
    output logic [ENERGY_W-1:0] energy,
    output logic [TRACER_W-1:0] tracer,
    output logic                dead
);

    localparam int CNT_W = $clog2(COOLDOWN) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FIRE,
        S_COOL,
        S_REFILL,
        S_DEAD
    } state_t;

    state_t              state, state_n;
    logic                sel, sel_n;
    logic                last, last_n;
    logic [1:0]          armed, armed_n;
    logic [1:0]          arm_clr;
    logic [1:0]          eligible;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [1:0]          deny_n;
    logic                load_need;
    logic [FLUID_W-1:0]  fluid_n;
    logic [ENERGY_W-1:0] energy_n;
    logic [TRACER_W-1:0] tracer_n;

    // Needs of the selected requester, captured when leaving IDLE so the
    // check and the debit see one consistent set of costs.
    logic [FLUID_W-1:0]  nf;
    logic [ENERGY_W-1:0] ne;
    logic [TRACER_W-1:0] nt;

    function automatic logic pool_covers(
        input logic [FLUID_W-1:0]  f_need,
        input logic [ENERGY_W-1:0] e_need,
        input logic [TRACER_W-1:0] t_need,
        input logic [FLUID_W-1:0]  f_lvl,
        input logic [ENERGY_W-1:0] e_lvl,
        input logic [TRACER_W-1:0] t_lvl
    );
        return (f_need <= f_lvl) && (e_need <= e_lvl) && (t_need <= t_lvl);
    endfunction

    assign eligible = req & armed;

    always_comb begin
        state_n   = state;
        sel_n     = sel;
        last_n    = last;
        cnt_n     = cnt;
        deny_n    = 2'b00;
        load_need = 1'b0;
        arm_clr   = 2'b00;
        fluid_n   = fluid;
        energy_n  = energy;
        tracer_n  = tracer;

        case (state)
            S_IDLE: begin
                if (refill_req) begin
                    state_n = S_REFILL;
                    fluid_n = FLUID_W'(REFILL_F);
                end else if (eligible != 2'b00) begin
                    state_n   = S_CHECK;
                    load_need = 1'b1;
                    // Tie goes to the requester that was not served last.
                    sel_n     = (eligible == 2'b11) ? ~last : eligible[1];
                end
            end
            S_CHECK: begin
                // Serving a request disarms it whichever way the check goes,
                // so a held request cannot retrigger from the following IDLE.
                last_n       = sel;
                arm_clr[sel] = 1'b1;
                if (pool_covers(nf, ne, nt, fluid, energy, tracer)) begin
                    state_n  = S_FIRE;
                    fluid_n  = fluid - nf;
                    energy_n = energy - ne;
                    tracer_n = tracer - nt;
                end else begin
                    state_n     = S_IDLE;
                    deny_n[sel] = 1'b1;
                end
            end
            S_FIRE: begin
                cnt_n   = '0;
                state_n = (energy == '0) ? S_DEAD : S_COOL;
            end
            S_COOL: begin
                if (cnt == CNT_W'(COOLDOWN - 1)) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_REFILL: begin
                if (!refill_req) begin
                    state_n = S_IDLE;
                end
            end
            S_DEAD: begin
                state_n = S_DEAD;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // A low request re-arms even in the cycle it is being disarmed, so
        // a one-cycle drop anywhere is enough to earn another shot.
        armed_n = (armed & ~arm_clr) | ~req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            sel    <= 1'b0;
            last   <= 1'b1;
            armed  <= 2'b11;
            cnt    <= '0;
            deny   <= 2'b00;
            fluid  <= FLUID_W'(REFILL_F);
            energy <= ENERGY_W'(INIT_E);
            tracer <= TRACER_W'(INIT_T);
        end else begin
            state  <= state_n;
            sel    <= sel_n;
            last   <= last_n;
            armed  <= armed_n;
            cnt    <= cnt_n;
            deny   <= deny_n;
            fluid  <= fluid_n;
            energy <= energy_n;
            tracer <= tracer_n;
        end
    end

    always_ff @(posedge clk) begin
        if (load_need) begin
            nf <= sel_n ? need_f1 : need_f0;
            ne <= sel_n ? need_e1 : need_e0;
            nt <= sel_n ? need_t1 : need_t0;
        end
    end

    assign grant = (state == S_FIRE) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign busy  = (state != S_IDLE) && (state != S_DEAD);
    assign dead  = (state == S_DEAD);

endmodule

// File: tb/tb_web_fire_arbiter.sv
// Directed bench for web_fire_arbiter (default parameters, COOLDOWN=3).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_web_fire_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [4:0] need_f0, need_f1;
    logic [8:0] need_e0, need_e1;
    logic [6:0] need_t0, need_t1;
    logic       refill_req;
    logic [1:0] grant, deny;
    logic       busy, dead;
    logic [4:0] fluid;
    logic [8:0] energy;
    logic [6:0] tracer;

    int n_cmp = 0;
    int n_bad = 0;

    web_fire_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .need_f0    (need_f0),
        .need_f1    (need_f1),
        .need_e0    (need_e0),
        .need_e1    (need_e1),
        .need_t0    (need_t0),
        .need_t1    (need_t1),
        .refill_req (refill_req),
        .grant      (grant),
        .deny       (deny),
        .busy       (busy),
        .fluid      (fluid),
        .energy     (energy),
        .tracer     (tracer),
        .dead       (dead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set0(input logic [4:0] f, input logic [8:0] e, input logic [6:0] t);
        need_f0 = f; need_e0 = e; need_t0 = t;
    endtask

    task automatic set1(input logic [4:0] f, input logic [8:0] e, input logic [6:0] t);
        need_f1 = f; need_e1 = e; need_t1 = t;
    endtask

    task automatic chk_pool(input string tag, input int f, input int e, input int t);
        chk({tag, "_fluid"},  32'(fluid),  32'(f));
        chk({tag, "_energy"}, 32'(energy), 32'(e));
        chk({tag, "_tracer"}, 32'(tracer), 32'(t));
    endtask

    initial begin
        int gcount;
        int pulses;

        rst_n = 1'b0; req = 2'b00; refill_req = 1'b0;
        set0(0, 0, 0); set1(0, 0, 0);
        cyc(3);

        // Reset state
        chk("rst_grant", 32'(grant), 0);
        chk("rst_deny",  32'(deny),  0);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_dead",  32'(dead),  0);
        chk_pool("rst", 16, 256, 64);
        rst_n = 1'b1;
        cyc(1);

        // Single shot from requester 0
        req = 2'b01; set0(1, 1, 0);
        cyc(1);
        chk("t1_busy_check", 32'(busy), 1);
        chk("t1_grant_early", 32'(grant), 0);
        cyc(1);
        chk("t1_grant", 32'(grant), 32'b01);
        chk_pool("t1", 15, 255, 64);
        req = 2'b00;
        cyc(1);
        chk("t1_grant_pulse", 32'(grant), 0);
        cyc(3);
        chk("t1_idle", 32'(busy), 0);

        // Simultaneous requests: last=0 so requester 1 first, then 0 six cycles on
        set0(1, 1, 1); set1(2, 2, 2);
        req = 2'b11;
        cyc(2);
        chk("t2_grant_r1", 32'(grant), 32'b10);
        chk_pool("t2a", 13, 253, 62);
        cyc(5);
        chk("t2_gap", 32'(grant), 0);
        cyc(1);
        chk("t2_grant_r0", 32'(grant), 32'b01);
        chk_pool("t2b", 12, 252, 61);
        req = 2'b00;
        cyc(4);

        // Insufficient fluid -> deny, pool unchanged; refill; exact-fit shot
        req = 2'b01; set0(13, 1, 1);
        cyc(2);
        chk("t3_deny", 32'(deny), 32'b01);
        chk("t3_no_grant", 32'(grant), 0);
        chk_pool("t3_deny", 12, 252, 61);
        req = 2'b00;
        cyc(1);
        chk("t3_deny_pulse", 32'(deny), 0);
        refill_req = 1'b1;
        cyc(1);
        chk("t3_refill_busy", 32'(busy), 1);
        chk("t3_refill_fluid", 32'(fluid), 16);
        refill_req = 1'b0;
        cyc(1);
        chk("t3_refill_done", 32'(busy), 0);
        req = 2'b01; set0(16, 1, 1);
        cyc(2);
        chk("t3_grant", 32'(grant), 32'b01);
        chk_pool("t3_fire", 0, 251, 60);
        req = 2'b00;
        cyc(4);

        // Refill and request together: refill wins, shot follows refill release
        refill_req = 1'b1; req = 2'b01; set0(0, 1, 0);
        cyc(1);
        chk("t4_refill_fluid", 32'(fluid), 16);
        chk("t4_no_grant_a", 32'(grant), 0);
        cyc(1);
        chk("t4_no_grant_b", 32'(grant), 0);
        chk("t4_busy", 32'(busy), 1);
        refill_req = 1'b0;
        cyc(3);
        chk("t4_grant", 32'(grant), 32'b01);
        chk_pool("t4", 16, 250, 60);
        req = 2'b00;
        cyc(4);

        // Held request yields one shot; one-cycle drop re-arms
        req = 2'b01; set0(0, 1, 0);
        gcount = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (grant[0]) gcount++;
        end
        chk("t6_held_grants", 32'(gcount), 1);
        chk("t6_energy_a", 32'(energy), 249);
        req = 2'b00;
        cyc(1);
        req = 2'b01;
        cyc(2);
        chk("t6_rearm_grant", 32'(grant), 32'b01);
        chk("t6_energy_b", 32'(energy), 248);
        req = 2'b00;
        cyc(4);

        // Zero-cost shot from requester 1
        req = 2'b10; set1(0, 0, 0);
        cyc(2);
        chk("zero_grant", 32'(grant), 32'b10);
        chk_pool("zero", 16, 248, 60);
        req = 2'b00;
        cyc(4);

        // Spend the remaining energy -> DEAD
        req = 2'b01; set0(3, 248, 0);
        cyc(2);
        chk("t5_grant", 32'(grant), 32'b01);
        chk_pool("t5", 13, 0, 60);
        cyc(1);
        chk("t5_dead", 32'(dead), 1);
        chk("t5_busy", 32'(busy), 0);
        req = 2'b11; refill_req = 1'b1; set0(0, 0, 0); set1(0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if ((grant | deny) != 2'b00) pulses++;
        end
        chk("t5_dead_pulses", 32'(pulses), 0);
        chk("t5_dead_sticky", 32'(dead), 1);
        chk_pool("t5_frozen", 13, 0, 60);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_dead", 32'(dead), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk_pool("t5_rst", 16, 256, 64);
        req = 2'b00; refill_req = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        // Reset in the middle of a shot aborts it without a debit
        req = 2'b01; set0(1, 1, 1);
        cyc(1);
        chk("abort_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy_rst", 32'(busy), 0);
        cyc(1);
        chk("abort_grant", 32'(grant), 0);
        chk_pool("abort", 16, 256, 64);

        // First tie after reset goes to requester 0
        req = 2'b11; set0(0, 0, 0); set1(0, 0, 0);
        rst_n = 1'b1;
        cyc(2);
        chk("tie_after_reset", 32'(grant), 32'b01);
        req = 2'b00;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
